// File: rtl/sram_window_framegrab.sv
// sram_window_framegrab
// Captures a rectangular window of the VGA scan into external SRAM during one
// frame, then replays it on later frames (once, or looping). It can also pass
// live pixels through. o_pix feeds the VGA colour mux.
//
// Ports
//   i_clk, i_rst_n        pixel clock, asynchronous active-low reset
//   i_H_Cont, i_V_Cont    VGA scan counters (13 bit)
//   i_pix_vld, i_pix      incoming RGB555 pixel and its valid flag
//   i_mode                0 one-shot playback, 1 loop playback, 2/3 live
//   i_start               start pulse, sampled only while idle
//   i_abort               synchronous abort back to idle
//   i_s_data              SRAM read data; asynchronous SRAM, sampled one edge
//                         after o_s_addr is presented
//   o_s_data, o_s_wen,    SRAM write data {1'b0,pix}, write enable (active low)
//   o_s_addr              and address
//   o_pix                 display pixel (registered)
//   o_busy                high whenever the engine is not idle
//   o_done                one-cycle pulse when a one-shot playback completes
//   o_frames              completed playback frames, wraps at 255
module sram_window_framegrab #(
  parameter int          X_START  = 144,
  parameter int          Y_START  = 35,
  parameter int          WIN_W    = 640,
  parameter int          WIN_H    = 100,
  parameter int          ADDR_W   = 20,
  parameter logic [14:0] BG_COLOR = 15'h7fff
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [12:0]       i_H_Cont,
  input  logic [12:0]       i_V_Cont,
  input  logic              i_pix_vld,
  input  logic [14:0]       i_pix,
  input  logic [1:0]        i_mode,
  input  logic              i_start,
  input  logic              i_abort,
  input  logic [15:0]       i_s_data,
  output logic [15:0]       o_s_data,
  output logic              o_s_wen,
  output logic [ADDR_W-1:0] o_s_addr,
  output logic [14:0]       o_pix,
  output logic              o_busy,
  output logic              o_done,
  output logic [7:0]        o_frames
);

  localparam logic [12:0] LP_X0   = 13'(X_START);
  localparam logic [12:0] LP_X1   = 13'(X_START + WIN_W - 1);
  localparam logic [12:0] LP_XPRE = 13'(X_START - 1);
  localparam logic [12:0] LP_Y0   = 13'(Y_START);
  localparam logic [12:0] LP_Y1   = 13'(Y_START + WIN_H - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARM,
    ST_CAPT,
    ST_WAITP,
    ST_PLAY,
    ST_LIVE
  } state_t;

  state_t              r_state, w_state_next;
  logic                r_loop, w_loop_next;
  logic [ADDR_W-1:0]   r_idx, w_idx_next;     // next capture pixel index
  logic [ADDR_W-1:0]   r_s_addr, w_addr_next;
  logic [15:0]         r_s_data, w_data_next;
  logic                r_s_wen, w_wen_next;
  logic [14:0]         r_pix, w_pix_next;
  logic                r_done, w_done_next;
  logic [7:0]          r_frames, w_frames_next;

  logic w_in_win, w_last, w_at_start, w_at_pre;
  logic w_unused;

  // Bit 15 of the SRAM word is always written as zero and never displayed.
  assign w_unused = i_s_data[15];

  assign w_in_win   = (i_H_Cont >= LP_X0) && (i_H_Cont <= LP_X1) &&
                      (i_V_Cont >= LP_Y0) && (i_V_Cont <= LP_Y1);
  assign w_last     = (i_H_Cont == LP_X1) && (i_V_Cont == LP_Y1);
  assign w_at_start = (i_H_Cont == LP_X0) && (i_V_Cont == LP_Y0);
  assign w_at_pre   = (i_H_Cont == LP_XPRE) && (i_V_Cont == LP_Y0);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state  <= ST_IDLE;
      r_loop   <= 1'b0;
      r_idx    <= '0;
      r_s_addr <= '0;
      r_s_data <= '0;
      r_s_wen  <= 1'b1;
      r_pix    <= '0;
      r_done   <= 1'b0;
      r_frames <= '0;
    end else begin
      r_state  <= w_state_next;
      r_loop   <= w_loop_next;
      r_idx    <= w_idx_next;
      r_s_addr <= w_addr_next;
      r_s_data <= w_data_next;
      r_s_wen  <= w_wen_next;
      r_pix    <= w_pix_next;
      r_done   <= w_done_next;
      r_frames <= w_frames_next;
    end
  end

  always_comb begin
    w_state_next  = r_state;
    w_loop_next   = r_loop;
    w_idx_next    = r_idx;
    w_addr_next   = r_s_addr;
    w_data_next   = r_s_data;
    w_wen_next    = 1'b1;
    w_pix_next    = BG_COLOR;
    w_done_next   = 1'b0;
    w_frames_next = r_frames;

    case (r_state)
      ST_IDLE: begin
        if (i_start) begin
          w_loop_next  = (i_mode == 2'd1);
          w_state_next = i_mode[1] ? ST_LIVE : ST_ARM;
        end
      end

      // The first window pixel arrives on the same cycle that ARM recognises
      // the window origin, so it is written here rather than lost.
      ST_ARM: begin
        if (w_at_start) begin
          w_addr_next  = '0;
          w_idx_next   = ADDR_W'(1);
          w_data_next  = {1'b0, i_pix};
          w_wen_next   = ~i_pix_vld;
          w_state_next = w_last ? ST_WAITP : ST_CAPT;
        end
      end

      // Pixels inside the window arrive in raster order, so a running index
      // equals (V-Y_START)*WIN_W + (H-X_START) without a multiplier. Invalid
      // pixels still consume an index, leaving a hole in SRAM.
      ST_CAPT: begin
        if (w_in_win) begin
          w_addr_next = r_idx;
          w_idx_next  = r_idx + ADDR_W'(1);
          w_data_next = {1'b0, i_pix};
          w_wen_next  = ~i_pix_vld;
        end
        if (w_last) begin
          w_state_next = ST_WAITP;
        end
      end

      // Address 0 is loaded one column before the window so it is already
      // presented to the SRAM when the first window pixel is displayed.
      ST_WAITP: begin
        w_addr_next = '0;
        if (w_at_pre) begin
          w_state_next = ST_PLAY;
        end
      end

      // o_s_addr always holds the index of the pixel being displayed this
      // cycle. After a row's last column, +1 is the next row's start and it
      // is held through blanking until that row begins.
      ST_PLAY: begin
        w_pix_next = w_in_win ? i_s_data[14:0] : BG_COLOR;
        if (w_in_win) begin
          w_addr_next = r_s_addr + ADDR_W'(1);
        end
        if (w_last) begin
          w_addr_next   = '0;
          w_frames_next = r_frames + 8'd1;
          if (r_loop) begin
            w_state_next = ST_WAITP;
          end else begin
            w_state_next = ST_IDLE;
            w_done_next  = 1'b1;
          end
        end
      end

      ST_LIVE: begin
        w_pix_next = (w_in_win && i_pix_vld) ? i_pix : BG_COLOR;
      end

      default: begin
        w_state_next = ST_IDLE;
      end
    endcase

    // Abort wins over everything, including a write or frame end on the
    // same cycle: no write, no frame count, no done pulse.
    if (i_abort) begin
      w_state_next  = ST_IDLE;
      w_wen_next    = 1'b1;
      w_addr_next   = '0;
      w_done_next   = 1'b0;
      w_frames_next = r_frames;
    end
  end

  assign o_s_data = r_s_data;
  assign o_s_wen  = r_s_wen;
  assign o_s_addr = r_s_addr;
  assign o_pix    = r_pix;
  assign o_busy   = (r_state != ST_IDLE);
  assign o_done   = r_done;
  assign o_frames = r_frames;

endmodule
